// File: rtl/dffs_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register chain.
package dffs_pipe_pkg;

    localparam int unsigned MAX_DEPTH = 16;
    localparam int unsigned CNT_W     = 5;

    // Number of set bits in a MAX_DEPTH-wide valid vector.
    function automatic logic [CNT_W-1:0] count_ones(input logic [MAX_DEPTH-1:0] bits);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
            n = n + CNT_W'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/dffs_pipe_stage.sv
// One elastic register stage: valid flag plus data, loading whenever downstream has room.
module dffs_pipe_stage
    import dffs_pipe_pkg::*;
#(
    parameter int unsigned     DW  = 32,
    parameter logic [DW-1:0]   RDT = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          dn_ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic          rdy
);

    // Stage can take new contents when empty or when its contents move on this cycle.
    assign rdy = !valid | dn_ready;

    // Valid follows upstream when ready; clr empties the stage without touching data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (rdy) begin
            valid <= up_valid;
        end
    end

    // Data loads only for a real upstream datum so bubbles leave the old value in place.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= RDT;
        end else if (rdy && up_valid) begin
            data <= up_data;
        end
    end

endmodule

// File: rtl/dffs_pipe.sv
// Parametrised elastic pipeline: DEPTH valid/ready stages with bubble collapsing and flush.
module dffs_pipe
    import dffs_pipe_pkg::*;
#(
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 2,
    parameter logic [DW-1:0] RDT      = '0,
    parameter bit            FLUSH_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       i_valid,
    output logic                       i_ready,
    input  logic [DW-1:0]              i_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [DW-1:0]              o_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH:0]   rdy_chain;
    logic [DEPTH-1:0] v;
    logic [DW-1:0]    d [DEPTH];
    logic             flush_act;
    logic             in_acc;

    // Flush is a no-op in builds that do not honour it.
    assign flush_act = flush & FLUSH_EN;

    // Downstream readiness enters at the output end of the chain.
    assign rdy_chain[DEPTH] = o_ready;

    // Input is refused during flush so nothing new survives the clear.
    assign i_ready = rdy_chain[0] & !flush_act;
    assign in_acc  = i_valid & i_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic          up_v;
        logic [DW-1:0] up_d;

        // Stage 0 is fed by the accepted input, others by their predecessor.
        if (k == 0) begin : g_head
            assign up_v = in_acc;
            assign up_d = i_data;
        end else begin : g_body
            assign up_v = v[k-1];
            assign up_d = d[k-1];
        end

        dffs_pipe_stage #(
            .DW  (DW),
            .RDT (RDT)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (flush_act),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (rdy_chain[k+1]),
            .valid    (v[k]),
            .data     (d[k]),
            .rdy      (rdy_chain[k])
        );
    end

    assign o_valid = v[DEPTH-1];
    assign o_data  = d[DEPTH-1];

    // Occupancy is the popcount of the registered stage valids.
    assign occupancy = OCC_W'(count_ones(MAX_DEPTH'(v)));

endmodule

// File: tb/tb_dffs_pipe.sv
// Directed plus random scoreboard bench for dffs_pipe (DW=8, DEPTH=3, RDT=A5).
module tb_dffs_pipe;

    localparam int unsigned DW    = 8;
    localparam int unsigned D     = 3;
    localparam logic [7:0]  RDT_V = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n, flush, i_valid, o_ready;
    logic [7:0] i_data;
    logic       i_ready, o_valid;
    logic [7:0] o_data;
    logic [1:0] occupancy;
    logic       nf_i_ready, nf_o_valid;
    logic [7:0] nf_o_data;
    logic [1:0] nf_occupancy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];
    logic [D-1:0] mv;
    bit known = 1'b0;

    always #5 clk = ~clk;

    dffs_pipe #(.DW(DW), .DEPTH(D), .RDT(RDT_V), .FLUSH_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_valid(i_valid), .i_ready(i_ready),
        .i_data(i_data), .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .occupancy(occupancy)
    );

    dffs_pipe #(.DW(DW), .DEPTH(D), .RDT(RDT_V), .FLUSH_EN(1'b0)) dut_nf (
        .clk(clk), .rst_n(rst_n), .flush(flush), .i_valid(i_valid), .i_ready(nf_i_ready),
        .i_data(i_data), .o_valid(nf_o_valid), .o_ready(o_ready), .o_data(nf_o_data),
        .occupancy(nf_occupancy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [D-1:0] b);
        int n = 0;
        for (int k = 0; k < D; k++) n += int'(b[k]);
        return n;
    endfunction

    // One clock: drive at negedge, check against the model, advance the model, return just after posedge.
    task automatic cycle(input logic rv, input logic iv, input logic [7:0] id,
                         input logic ordy, input logic fl);
        logic exp_ir, acc, outx, r;
        logic [D-1:0] mr;
        @(negedge clk);
        rst_n = rv; i_valid = iv; i_data = id; o_ready = ordy; flush = fl;
        #1;
        exp_ir = !((popc(mv) == D) && !ordy) && !fl;
        if (known) begin
            chk("o_valid", 32'(o_valid), 32'(mv[D-1]));
            chk("occupancy", 32'(occupancy), 32'(popc(mv)));
            chk("i_ready", 32'(i_ready), 32'(exp_ir));
            if (mv[D-1]) begin
                if (q.size() > 0) chk("o_data", 32'(o_data), 32'(q[0]));
                else chk("sb_empty", 32'(q.size()), 32'd1);
            end
        end
        if (!rv) begin
            mv = '0;
            q.delete();
            known = 1'b1;
        end else if (known) begin
            outx = mv[D-1] & ordy;
            acc  = iv & exp_ir;
            if (outx) void'(q.pop_front());
            if (acc) q.push_back(id);
            r = ordy;
            for (int k = D - 1; k >= 0; k--) begin
                mr[k] = !mv[k] | r;
                r = mr[k];
            end
            for (int k = D - 1; k >= 1; k--) if (mr[k]) mv[k] = mv[k-1];
            if (mr[0]) mv[0] = acc;
            if (fl) begin
                mv = '0;
                q.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0; i_data = '0;

        // Reset and idle
        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_data", 32'(o_data), 32'(RDT_V));
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd1);
        cycle(1, 0, 8'h00, 1, 0);

        // Streaming 01..10 with full throughput
        for (int i = 1; i <= 16; i++) begin
            cycle(1, 1, 8'(i), 1, 0);
            if (i == 1 || i == 2) chk("lat_early", 32'(o_valid), 32'd0);
            if (i == 3) begin
                chk("lat_first", 32'(o_valid), 32'd1);
                chk("lat_data", 32'(o_data), 32'h01);
            end
            chk("stream_i_ready", 32'(i_ready), 32'd1);
        end
        for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00, 1, 0);

        // Full stall then release
        cycle(1, 1, 8'h11, 0, 0);
        cycle(1, 1, 8'h22, 0, 0);
        cycle(1, 1, 8'h33, 0, 0);
        chk("stall_occ", 32'(occupancy), 32'd3);
        chk("stall_i_ready", 32'(i_ready), 32'd0);
        chk("stall_o_data", 32'(o_data), 32'h11);
        cycle(1, 1, 8'h44, 0, 0);
        chk("stall_hold", 32'(o_data), 32'h11);
        cycle(1, 1, 8'h44, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'h00, 1, 0);

        // Bubble collapse
        cycle(1, 1, 8'h5A, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        cycle(1, 1, 8'h6B, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
        chk("bub_occ", 32'(occupancy), 32'd2);
        chk("bub_o_data", 32'(o_data), 32'h5A);
        chk("bub_stack", 32'(dut.v), 32'b110);
        cycle(1, 0, 8'h00, 1, 0);
        chk("bub_second", 32'(o_data), 32'h6B);
        for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00, 1, 0);

        // Flush mid-stream; the no-flush build keeps accepting
        cycle(1, 1, 8'h71, 0, 0);
        cycle(1, 1, 8'h72, 0, 0);
        chk("pre_flush_occ", 32'(occupancy), 32'd2);
        cycle(1, 1, 8'h73, 0, 1);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_o_valid", 32'(o_valid), 32'd0);
        chk("nf_occ", 32'(nf_occupancy), 32'd3);
        chk("nf_o_data", 32'(nf_o_data), 32'h71);
        cycle(1, 0, 8'h00, 1, 0);
        cycle(1, 0, 8'h00, 1, 0);

        // Reset while full
        cycle(0, 0, 8'h00, 0, 0);
        cycle(1, 1, 8'h81, 0, 0);
        cycle(1, 1, 8'h82, 0, 0);
        cycle(1, 1, 8'h83, 0, 0);
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        cycle(0, 1, 8'h84, 1, 0);
        chk("mid_rst_occ", 32'(occupancy), 32'd0);
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_o_data", 32'(o_data), 32'(RDT_V));

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            cycle(1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0));
        end
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'h00, 1, 0);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
